// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin owner arbitration for a shared 4:1 bit mux with a hold limit.
module mux_4x1_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       rel,
   input  logic [3:0] a,
   output logic [3:0] gnt,
   output logic [1:0] s,
   output logic       y,
   output logic       busy
);
   typedef enum logic {IDLE, OWN} state_t;
   localparam logic [3:0] HMAX = 4'(MAX_HOLD - 1);
   state_t     r_state;
   logic [1:0] r_ptr;
   logic [3:0] r_hcnt;
   logic [3:0] w_rot;
   logic [1:0] w_win;
   logic       w_rel;
   // w_rot[i] is req[(ptr+i) mod 4], so the lowest set bit is the round-robin winner
   always_comb begin
      w_rot = 4'({req, req} >> r_ptr);
      w_win = r_ptr + (w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3);
      w_rel = rel | ~req[s] | (r_hcnt == HMAX && (req & ~gnt) != 4'b0000);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_hcnt  <= 4'd0;
         gnt     <= 4'b0000;
         s       <= 2'd0;
         y       <= 1'b0;
         busy    <= 1'b0;
      end else if (r_state == IDLE) begin
         y <= 1'b0;
         if (req != 4'b0000) begin
            gnt     <= 4'b0001 << w_win;
            s       <= w_win;
            r_hcnt  <= 4'd0;
            busy    <= 1'b1;
            r_state <= OWN;
         end
      end else begin
         y <= a[s];
         if (w_rel) begin
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            r_ptr   <= s + 2'd1;
            r_state <= IDLE;
         end else if (r_hcnt != HMAX) begin
            r_hcnt <= r_hcnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// tb_mux_4x1_rr_arbiter: directed stimulus with a queued scoreboard for mux_4x1_rr_arbiter.
module tb_mux_4x1_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] a;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       busy;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic [7:0] e;
  logic [7:0] got;
  string      nm;
  logic [3:0] av;
  int         checks = 0;
  int         failures = 0;
  event       chk_ev;
  mux_4x1_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .a(a),
    .gnt(gnt), .s(s), .y(y), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [3:0] r, input logic rl, input logic [3:0] ai,
                      input logic [3:0] eg, input logic [1:0] es, input logic ey,
                      input logic eb, input string n);
    @(negedge clk);
    req = r;
    rel = rl;
    a   = ai;
    exp_q.push_back({eg, es, ey, eb});
    nm_q.push_back(n);
    @(posedge clk);
  endtask
  always begin
    @(posedge clk or chk_ev);
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = nm_q.pop_front();
      got = {gnt, s, y, busy};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got gnt=%b s=%0d y=%b busy=%b, expected gnt=%b s=%0d y=%b busy=%b",
                 nm, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
      end
      if ((gnt & (gnt - 4'd1)) !== 4'b0000) begin
        failures++;
        $display("FAIL %s: gnt=%b not zero or one-hot", nm, gnt);
      end
      if (gnt !== 4'b0000 && (gnt[s] !== 1'b1 || busy !== 1'b1)) begin
        failures++;
        $display("FAIL %s: gnt=%b s=%0d busy=%b inconsistent", nm, gnt, s, busy);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; req = 4'b0000; rel = 1'b0; a = 4'b0000;
    step(4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset");
    #2 rst = 1'b0;
    step(4'b0100, 0, 4'b0100, 4'b0100, 2'd2, 0, 1, "single_grant");
    step(4'b0100, 0, 4'b0100, 4'b0100, 2'd2, 1, 1, "single_y1");
    step(4'b0100, 0, 4'b0000, 4'b0100, 2'd2, 0, 1, "single_y0");
    step(4'b0100, 1, 4'b0100, 4'b0000, 2'd2, 1, 0, "single_rel");
    step(4'b0000, 0, 4'b0100, 4'b0000, 2'd2, 0, 0, "idle_y0");
    step(4'b1111, 1, 4'b0000, 4'b1000, 2'd3, 0, 1, "rr_grant3");
    step(4'b1111, 1, 4'b0000, 4'b0000, 2'd3, 0, 0, "rr_idle3");
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1, 4'b0000, 4'b0001 << (k % 4), 2'(k % 4), 0, 1, "rr_grant");
      step(4'b1111, 1, 4'b0000, 4'b0000, 2'(k % 4), 0, 0, "rr_idle");
    end
    step(4'b0011, 0, 4'b0010, 4'b0010, 2'd1, 0, 1, "fr_grant1");
    for (int k = 0; k < 7; k++) step(4'b0011, 0, 4'b0010, 4'b0010, 2'd1, 1, 1, "fr_hold1");
    step(4'b0011, 0, 4'b0010, 4'b0000, 2'd1, 1, 0, "fr_rotate1");
    step(4'b0011, 0, 4'b0010, 4'b0001, 2'd0, 0, 1, "fr_grant0");
    for (int k = 0; k < 7; k++) step(4'b0011, 0, 4'b0010, 4'b0001, 2'd0, 0, 1, "fr_hold0");
    step(4'b0011, 0, 4'b0010, 4'b0000, 2'd0, 0, 0, "fr_rotate0");
    step(4'b1000, 0, 4'b0000, 4'b1000, 2'd3, 0, 1, "lone_grant3");
    for (int i = 0; i < 20; i++) begin
      av = 4'(i * 5);
      step(4'b1000, 0, av, 4'b1000, 2'd3, av[3], 1, "lone_hold");
    end
    step(4'b0001, 0, 4'b1000, 4'b0000, 2'd3, 1, 0, "drop3");
    step(4'b0001, 1, 4'b0000, 4'b0001, 2'd0, 0, 1, "wrap_grant0");
    step(4'b0001, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, "rel0");
    step(4'b0100, 0, 4'b0100, 4'b0100, 2'd2, 0, 1, "pre_rst_grant2");
    step(4'b0100, 0, 4'b0100, 4'b0100, 2'd2, 1, 1, "pre_rst_own2");
    #3 rst = 1'b1;
    exp_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
    nm_q.push_back("async_rst");
    -> chk_ev;
    step(4'b0100, 0, 4'b0100, 4'b0000, 2'd0, 0, 0, "held_rst");
    #2 rst = 1'b0;
    step(4'b1111, 0, 4'b0000, 4'b0001, 2'd0, 0, 1, "post_rst_grant0");
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
